// File: rtl/decode_pkg.sv
// Shared encodings for the decode sequencer: ALU op codes, phases, RV32I opcodes
// and the decoded-instruction payload.
package decode_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned PHASE_W = 3;

    // ALU op codes, identical to the ALU's own encoding
    localparam logic [OP_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [OP_W-1:0] ALU_SLTI   = 5'd1;
    localparam logic [OP_W-1:0] ALU_SLTU   = 5'd2;
    localparam logic [OP_W-1:0] ALU_XORI   = 5'd3;
    localparam logic [OP_W-1:0] ALU_ORI    = 5'd4;
    localparam logic [OP_W-1:0] ALU_ANDI   = 5'd5;
    localparam logic [OP_W-1:0] ALU_SLLI   = 5'd6;
    localparam logic [OP_W-1:0] ALU_SRLI   = 5'd7;
    localparam logic [OP_W-1:0] ALU_SRAI   = 5'd8;
    localparam logic [OP_W-1:0] ALU_SUB    = 5'd9;
    localparam logic [OP_W-1:0] ALU_SLL    = 5'd10;
    localparam logic [OP_W-1:0] ALU_SLT    = 5'd11;
    localparam logic [OP_W-1:0] ALU_XOR    = 5'd13;
    localparam logic [OP_W-1:0] ALU_SRL    = 5'd14;
    localparam logic [OP_W-1:0] ALU_SRA    = 5'd15;
    localparam logic [OP_W-1:0] ALU_OR     = 5'd16;
    localparam logic [OP_W-1:0] ALU_AND    = 5'd17;
    localparam logic [OP_W-1:0] ALU_BEQ    = 5'd18;
    localparam logic [OP_W-1:0] ALU_BNE    = 5'd19;
    localparam logic [OP_W-1:0] ALU_BLT    = 5'd20;
    localparam logic [OP_W-1:0] ALU_BGE    = 5'd21;
    localparam logic [OP_W-1:0] ALU_BLTU   = 5'd22;
    localparam logic [OP_W-1:0] ALU_BGEU   = 5'd23;

    typedef enum logic [PHASE_W-1:0] {
        PH_FETCH  = 3'd0,
        PH_DECODE = 3'd1,
        PH_EXEC   = 3'd2,
        PH_MEM    = 3'd3,
        PH_WB     = 3'd4
    } phase_t;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] opa;
        logic [XLEN-1:0] opb;
        logic [XLEN-1:0] imm;
        logic            writes_rd;
        logic            is_branch;
        logic            is_load;
        logic            is_store;
        logic            is_jump;
        logic            legal;
    } dec_t;

endpackage

// File: rtl/decode_sequencer_imm_gen.sv
// Combinational RV32I immediate extraction; all formats sign-extend from instr[31].
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:7]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/decode_sequencer.sv
// Phase sequencer and RV32I decoder feeding the ALU.
// Optional feature: DECODE_ILLEGAL_TRAP_EN drives the illegal flag for unknown words.
module decode_sequencer
    import decode_pkg::*;
#(
    parameter logic [2:0]  RESET_PHASE = 3'd0,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        mem_done,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [2:0]  phase,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_opa,
    output logic [31:0] alu_opb,
    output logic [31:0] imm,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic        is_branch,
    output logic        is_load,
    output logic        is_store,
    output logic        is_jump,
    output logic        illegal
);

    phase_t          phase_q;
    logic [31:0]     instr_q;
    logic [31:0]     pc_q;
    logic            writes_rd_q;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    dec_t            dec_raw;
    dec_t            dec_c;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] shamt;

    assign opc      = instr_q[6:0];
    assign f3       = instr_q[14:12];
    assign f7       = instr_q[31:25];
    assign shamt    = {27'b0, instr_q[24:20]};
    assign rs1_addr = instr_q[19:15];
    assign rs2_addr = instr_q[24:20];
    assign phase    = phase_q;

    imm_gen u_imm_gen (
        .instr (instr_q[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    // Decode of the latched word; unknown words collapse to an all-zero (add 0+0) payload
    always_comb begin
        dec_raw = '0;
        unique case (opc)
            OPC_OP_IMM: begin
                dec_raw.legal     = 1'b1;
                dec_raw.writes_rd = 1'b1;
                dec_raw.opa       = rs1_data;
                dec_raw.opb       = imm_i;
                dec_raw.imm       = imm_i;
                unique case (f3)
                    3'b000: dec_raw.op = ALU_ADD;
                    3'b001: begin dec_raw.op = ALU_SLLI; dec_raw.opb = shamt; end
                    3'b010: dec_raw.op = ALU_SLTI;
                    3'b011: dec_raw.op = ALU_SLTU;
                    3'b100: dec_raw.op = ALU_XORI;
                    3'b101: begin
                        dec_raw.op  = instr_q[30] ? ALU_SRAI : ALU_SRLI;
                        dec_raw.opb = shamt;
                    end
                    3'b110: dec_raw.op = ALU_ORI;
                    default: dec_raw.op = ALU_ANDI;
                endcase
            end
            OPC_OP: begin
                dec_raw.legal     = (f7 == 7'h00) || (f7 == 7'h20);
                dec_raw.writes_rd = 1'b1;
                dec_raw.opa       = rs1_data;
                dec_raw.opb       = rs2_data;
                unique case (f3)
                    3'b000: dec_raw.op = instr_q[30] ? ALU_SUB : ALU_ADD;
                    3'b001: dec_raw.op = ALU_SLL;
                    3'b010: dec_raw.op = ALU_SLT;
                    3'b011: dec_raw.op = ALU_SLTU;
                    3'b100: dec_raw.op = ALU_XOR;
                    3'b101: dec_raw.op = instr_q[30] ? ALU_SRA : ALU_SRL;
                    3'b110: dec_raw.op = ALU_OR;
                    default: dec_raw.op = ALU_AND;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_raw.legal     = 1'b1;
                dec_raw.writes_rd = 1'b1;
                dec_raw.opa       = (opc == OPC_AUIPC) ? pc_q : '0;
                dec_raw.opb       = imm_u;
                dec_raw.imm       = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                dec_raw.legal     = (opc == OPC_JAL) || (f3 == 3'b000);
                dec_raw.writes_rd = 1'b1;
                dec_raw.is_jump   = 1'b1;
                dec_raw.opa       = pc_q;
                dec_raw.opb       = 32'd4;
                dec_raw.imm       = (opc == OPC_JAL) ? imm_j : imm_i;
            end
            OPC_LOAD: begin
                dec_raw.legal     = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                dec_raw.writes_rd = 1'b1;
                dec_raw.is_load   = 1'b1;
                dec_raw.opa       = rs1_data;
                dec_raw.opb       = imm_i;
                dec_raw.imm       = imm_i;
            end
            OPC_STORE: begin
                dec_raw.legal    = (f3 <= 3'b010);
                dec_raw.is_store = 1'b1;
                dec_raw.opa      = rs1_data;
                dec_raw.opb      = imm_s;
                dec_raw.imm      = imm_s;
            end
            OPC_BRANCH: begin
                dec_raw.legal     = (f3 != 3'b010) && (f3 != 3'b011);
                dec_raw.is_branch = 1'b1;
                dec_raw.opa       = rs1_data;
                dec_raw.opb       = rs2_data;
                dec_raw.imm       = imm_b;
                unique case (f3)
                    3'b000: dec_raw.op = ALU_BEQ;
                    3'b001: dec_raw.op = ALU_BNE;
                    3'b100: dec_raw.op = ALU_BLT;
                    3'b101: dec_raw.op = ALU_BGE;
                    3'b110: dec_raw.op = ALU_BLTU;
                    3'b111: dec_raw.op = ALU_BGEU;
                    default: dec_raw.op = ALU_ADD;
                endcase
            end
            default: dec_raw = '0;
        endcase
        dec_c = dec_raw.legal ? dec_raw : '0;
    end

    // Phase sequencing; decoded operands are captured once on DECODE exit and held through WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= phase_t'(RESET_PHASE);
            instr_q     <= NOP_WORD;
            pc_q        <= '0;
            alu_op      <= '0;
            alu_opa     <= '0;
            alu_opb     <= '0;
            imm         <= '0;
            rd_addr     <= '0;
            writes_rd_q <= 1'b0;
            is_branch   <= 1'b0;
            is_load     <= 1'b0;
            is_store    <= 1'b0;
            is_jump     <= 1'b0;
            rd_we       <= 1'b0;
        end else begin
            rd_we <= 1'b0;
            unique case (phase_q)
                PH_FETCH: begin
                    if (imem_valid) begin
                        instr_q <= imem_rdata;
                        pc_q    <= pc;
                        phase_q <= PH_DECODE;
                    end
                end
                PH_DECODE: begin
                    alu_op      <= dec_c.op;
                    alu_opa     <= dec_c.opa;
                    alu_opb     <= dec_c.opb;
                    imm         <= dec_c.imm;
                    rd_addr     <= instr_q[11:7];
                    writes_rd_q <= dec_c.writes_rd;
                    is_branch   <= dec_c.is_branch;
                    is_load     <= dec_c.is_load;
                    is_store    <= dec_c.is_store;
                    is_jump     <= dec_c.is_jump;
                    phase_q     <= PH_EXEC;
                end
                PH_EXEC: begin
                    if (is_load || is_store) begin
                        phase_q <= PH_MEM;
                    end else begin
                        phase_q <= PH_WB;
                        rd_we   <= writes_rd_q && (rd_addr != 5'd0);
                    end
                end
                PH_MEM: begin
                    if (mem_done) begin
                        phase_q <= PH_WB;
                        rd_we   <= writes_rd_q && (rd_addr != 5'd0);
                    end
                end
                PH_WB:   phase_q <= PH_FETCH;
                default: phase_q <= PH_FETCH;
            endcase
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Illegal flag spans DECODE exit through WB only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (phase_q == PH_DECODE) begin
            illegal <= ~dec_raw.legal;
        end else if (phase_q == PH_WB) begin
            illegal <= 1'b0;
        end
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer with a spec-level decode model and per-cycle compare.
module tb_decode_sequencer;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        wr;
        logic        br;
        logic        ld;
        logic        st;
        logic        jp;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        mem_done;
    logic [4:0]  rs1_addr, rs2_addr, alu_op, rd_addr;
    logic [2:0]  phase;
    logic [31:0] alu_opa, alu_opb, imm;
    logic        rd_we, is_branch, is_load, is_store, is_jump, illegal;

    int checks = 0;
    int errors = 0;

    logic        chk_en = 1'b0;
    logic [2:0]  exp_phase;
    exp_t        exp_dec;
    logic [4:0]  exp_rd, exp_rs1, exp_rs2;
    logic        exp_we, exp_ill;

    logic [31:0] trace;
    logic [4:0]  snap_op;
    logic [31:0] snap_opa, snap_opb, snap_imm;
    logic        snap_br, snap_ill, saw_we;
    logic [4:0]  wb_rd;

    decode_sequencer dut (
        .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .mem_done(mem_done),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .phase(phase), .alu_op(alu_op),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .imm(imm), .rd_addr(rd_addr), .rd_we(rd_we),
        .is_branch(is_branch), .is_load(is_load), .is_store(is_store), .is_jump(is_jump),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // Spec-level decode: table lookups on funct3, immediates assembled from bit fields
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [4:0]  t_imm [8] = '{5'd0, 5'd6, 5'd1, 5'd2, 5'd3, 5'd7, 5'd4, 5'd5};
        logic [4:0]  t_op  [8] = '{5'd0, 5'd10, 5'd11, 5'd2, 5'd13, 5'd14, 5'd16, 5'd17};
        logic [4:0]  t_br  [8] = '{5'd18, 5'd19, 5'd0, 5'd0, 5'd20, 5'd21, 5'd22, 5'd23};
        logic [31:0] ii, ss, bb, uu, jj;
        int f3;
        bit ok;
        f3 = int'(w[14:12]);
        ii = {{20{w[31]}}, w[31:20]};
        ss = {{20{w[31]}}, w[31:25], w[11:7]};
        bb = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        uu = {w[31:12], 12'h000};
        jj = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        e = '0;
        ok = 1'b0;
        case (w[6:0])
            7'h13: begin
                ok = 1; e.wr = 1; e.a = r1; e.imm = ii; e.op = t_imm[f3];
                e.b = (f3 == 1 || f3 == 5) ? 32'(w[24:20]) : ii;
                if (f3 == 5 && w[30]) e.op = 5'd8;
            end
            7'h33: begin
                ok = (w[31:25] == 7'h00) || (w[31:25] == 7'h20);
                e.wr = 1; e.a = r1; e.b = r2; e.op = t_op[f3];
                if (f3 == 0 && w[30]) e.op = 5'd9;
                if (f3 == 5 && w[30]) e.op = 5'd15;
            end
            7'h37: begin ok = 1; e.wr = 1; e.b = uu; e.imm = uu; end
            7'h17: begin ok = 1; e.wr = 1; e.a = p; e.b = uu; e.imm = uu; end
            7'h6f: begin ok = 1; e.wr = 1; e.jp = 1; e.a = p; e.b = 4; e.imm = jj; end
            7'h67: begin ok = (f3 == 0); e.wr = 1; e.jp = 1; e.a = p; e.b = 4; e.imm = ii; end
            7'h03: begin ok = (f3 inside {0, 1, 2, 4, 5}); e.wr = 1; e.ld = 1; e.a = r1; e.b = ii; e.imm = ii; end
            7'h23: begin ok = (f3 <= 2); e.st = 1; e.a = r1; e.b = ss; e.imm = ss; end
            7'h63: begin ok = !(f3 inside {2, 3}); e.br = 1; e.a = r1; e.b = r2; e.imm = bb; e.op = t_br[f3]; end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic trap_on();
`ifdef DECODE_ILLEGAL_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Per-cycle compare of every output against the bench's expected state
    always @(negedge clk) begin
        if (chk_en) begin
            chk("phase", 32'(phase), 32'(exp_phase));
            chk("alu_op", 32'(alu_op), 32'(exp_dec.op));
            chk("alu_opa", alu_opa, exp_dec.a);
            chk("alu_opb", alu_opb, exp_dec.b);
            chk("imm", imm, exp_dec.imm);
            chk("rd_addr", 32'(rd_addr), 32'(exp_rd));
            chk("rd_we", 32'(rd_we), 32'(exp_we));
            chk("rs1_addr", 32'(rs1_addr), 32'(exp_rs1));
            chk("rs2_addr", 32'(rs2_addr), 32'(exp_rs2));
            chk("flags", {28'd0, is_branch, is_load, is_store, is_jump},
                {28'd0, exp_dec.br, exp_dec.ld, exp_dec.st, exp_dec.jp});
            chk("illegal", 32'(illegal), 32'(exp_ill));
        end
    end

    task automatic set_reset_exp();
        exp_phase = 3'd0;
        exp_dec   = '0;
        exp_rd    = 5'd0;
        exp_rs1   = 5'd0;
        exp_rs2   = 5'd0;
        exp_we    = 1'b0;
        exp_ill   = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        trace = {trace[27:0], 1'b0, phase};
        if (phase == 3'd2) begin
            snap_op  = alu_op;
            snap_opa = alu_opa;
            snap_opb = alu_opb;
            snap_imm = imm;
            snap_br  = is_branch;
            snap_ill = illegal;
        end
        if (rd_we) begin
            saw_we = 1'b1;
            wb_rd  = rd_addr;
        end
        #1;
    endtask

    // From FETCH, run through DECODE so the DUT sits in EXEC on return
    task automatic fetch_decode(input logic [31:0] w, input logic [31:0] p,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input int fetch_wait, output exp_t m);
        m = model(w, p, r1, r2);
        trace = '0; saw_we = 1'b0; wb_rd = '0;
        for (int i = 0; i < fetch_wait; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            mem_done   = 1'b1;
            exp_phase  = 3'd0;
            step();
        end
        imem_valid = 1'b1;
        imem_rdata = w;
        pc         = p;
        rs1_data   = r1;
        rs2_data   = r2;
        mem_done   = 1'b0;
        exp_phase  = 3'd1;
        exp_rs1    = w[19:15];
        exp_rs2    = w[24:20];
        step();
        imem_valid = 1'b0;
        imem_rdata = '0;
        pc         = p + 32'd100;
        exp_phase  = 3'd2;
        exp_dec    = m;
        exp_rd     = w[11:7];
        exp_ill    = trap_on() & m.ill;
        step();
        rs1_data = $urandom;
        rs2_data = $urandom;
    endtask

    task automatic run_instr(input logic [31:0] w, input logic [31:0] p,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input int fetch_wait, input int mem_cycles);
        exp_t m;
        logic we;
        logic is_mem;
        fetch_decode(w, p, r1, r2, fetch_wait, m);
        we     = m.wr && (w[11:7] != 5'd0);
        is_mem = m.ld || m.st;
        mem_done  = 1'b1;
        exp_phase = is_mem ? 3'd3 : 3'd4;
        exp_we    = is_mem ? 1'b0 : we;
        step();
        if (is_mem) begin
            for (int k = 0; k < mem_cycles; k++) begin
                mem_done  = (k == mem_cycles - 1);
                exp_phase = (k == mem_cycles - 1) ? 3'd4 : 3'd3;
                exp_we    = (k == mem_cycles - 1) ? we : 1'b0;
                step();
            end
        end
        mem_done  = 1'b0;
        exp_phase = 3'd0;
        exp_we    = 1'b0;
        exp_ill   = 1'b0;
        step();
    endtask

    initial begin
        exp_t m;
        rst = 1'b1;
        imem_rdata = '0; imem_valid = 1'b0; pc = '0;
        rs1_data = '0; rs2_data = '0; mem_done = 1'b0;
        set_reset_exp();
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // addi x5,x1,-1
        run_instr(32'hFFF08293, 32'h0000_0000, 32'd7, 32'd0, 0, 0);
        chk("addi_op", 32'(snap_op), 32'd0);
        chk("addi_opa", snap_opa, 32'd7);
        chk("addi_opb", snap_opb, 32'hFFFF_FFFF);
        chk("addi_we", 32'(saw_we), 32'd1);
        chk("addi_rd", 32'(wb_rd), 32'd5);
        chk("addi_trace", trace, 32'h0000_1240);

        // srai x3,x3,4
        run_instr(32'h4041D193, 32'h0000_0004, 32'h8000_0040, 32'd0, 0, 0);
        chk("srai_op", 32'(snap_op), 32'd8);
        chk("srai_opb", snap_opb, 32'd4);

        // lw x2,8(x1) with three MEM cycles
        run_instr(32'h0080A103, 32'h0000_0008, 32'h0000_0100, 32'd0, 0, 3);
        chk("lw_opa", snap_opa, 32'h100);
        chk("lw_opb", snap_opb, 32'd8);
        chk("lw_trace", trace, 32'h0123_3340);
        chk("lw_rd", 32'(wb_rd), 32'd2);

        // bge x1,x2,+16
        run_instr(32'h0020D863, 32'h0000_000C, 32'd5, 32'd3, 0, 0);
        chk("bge_op", 32'(snap_op), 32'd21);
        chk("bge_opa", snap_opa, 32'd5);
        chk("bge_opb", snap_opb, 32'd3);
        chk("bge_imm", snap_imm, 32'd16);
        chk("bge_br", 32'(snap_br), 32'd1);
        chk("bge_we", 32'(saw_we), 32'd0);

        // all-ones word
        run_instr(32'hFFFF_FFFF, 32'h0000_0010, 32'd9, 32'd9, 0, 0);
        chk("ones_ill", 32'(snap_ill), 32'(trap_on()));
        chk("ones_op", 32'(snap_op), 32'd0);
        chk("ones_opa", snap_opa, 32'd0);
        chk("ones_opb", snap_opb, 32'd0);
        chk("ones_we", 32'(saw_we), 32'd0);

        // add after a 5-cycle imem stall with stray mem_done
        run_instr(32'h002083B3, 32'h0000_0014, 32'd10, 32'd20, 5, 0);
        chk("stall_trace", trace, 32'h0000_1240);
        run_instr(32'h40208433, 32'h0000_0018, 32'd10, 32'd20, 0, 0);
        run_instr(32'h123454B7, 32'h0000_001C, 32'd1, 32'd2, 1, 0);
        run_instr(32'h00001517, 32'h0000_0400, 32'd1, 32'd2, 0, 0);
        run_instr(32'h008000EF, 32'h0000_0080, 32'd1, 32'd2, 0, 0);
        run_instr(32'h004100E7, 32'h0000_0084, 32'd1, 32'd2, 0, 0);
        run_instr(32'h0020A223, 32'h0000_0088, 32'h200, 32'h55, 0, 1);
        run_instr(32'h00500013, 32'h0000_008C, 32'd1, 32'd2, 0, 0);
        chk("x0_we", 32'(saw_we), 32'd0);

        // reset while in EXEC
        fetch_decode(32'hFFF08293, 32'h0000_0090, 32'd7, 32'd0, 0, m);
        #1 rst = 1'b1;
        #1;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_op", 32'(alu_op), 32'd0);
        chk("rst_opa", alu_opa, 32'd0);
        set_reset_exp();
        step();
        rst = 1'b0;
        step();
        chk("rst_no_we", 32'(saw_we), 32'd0);
        run_instr(32'h002083B3, 32'h0000_0094, 32'd3, 32'd4, 0, 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
